// File: rtl/video_mode_detect_if.sv
// video_mode_detect_if: raw sync inputs and the measured video mode descriptor.
interface video_mode_detect_if;
  logic hs_in;
  logic vs_in;
  logic [11:0] h_period;
  logic [10:0] v_lines;
  logic hs_pol;
  logic vs_pol;
  logic is15k;
  logic is31k;
  logic valid;
  logic changed;
  modport master(
    output hs_in, vs_in,
    input h_period, v_lines, hs_pol, vs_pol, is15k, is31k, valid, changed
  );
  modport slave(
    input hs_in, vs_in,
    output h_period, v_lines, hs_pol, vs_pol, is15k, is31k, valid, changed
  );
endinterface

// File: rtl/video_mode_detect.sv
// video_mode_detect: measures hs/vs timing and publishes a debounced video mode descriptor.
module video_mode_detect #(
  parameter int TOL = 2
) (
  input logic clk_32,
  input logic reset,
  video_mode_detect_if.slave vm
);
  typedef enum logic [1:0] {NOSIG, ACQUIRE, LOCKED} state_t;
  typedef struct packed {
    logic [11:0] hp;
    logic [10:0] vl;
    logic hs;
    logic vs;
  } samp_t;
  state_t state, state_n;
  samp_t f, p, p_n, c, c_n;
  logic [2:0] hs_sr, vs_sr;
  logic hs_rise, vs_rise, hs_pol_m, line_pol, timeout;
  logic [11:0] hcnt, hhigh, line_period;
  logic [10:0] vcnt, vhigh, vcnt_f, vhigh_f;
  logic valid, valid_n, changed, changed_n;
  assign hs_rise = hs_sr[1] & ~hs_sr[2];
  assign vs_rise = vs_sr[1] & ~vs_sr[2];
  assign hs_pol_m = {hhigh, 1'b0} < {1'b0, hcnt};
  // a line ending on the vs rise cycle still belongs to the closing frame
  assign vcnt_f = (hs_rise && vcnt != 11'h7ff) ? vcnt + 11'd1 : vcnt;
  assign vhigh_f = (hs_rise && vs_sr[1] && vhigh != 11'h7ff) ? vhigh + 11'd1 : vhigh;
  assign f = {hs_rise ? hcnt : line_period, vcnt_f, hs_rise ? hs_pol_m : line_pol,
              {vhigh_f, 1'b0} < {1'b0, vcnt_f}};
  assign timeout = hcnt == 12'hfff || vcnt == 11'h7ff;
  always_ff @(posedge clk_32 or posedge reset)
    if (reset) begin
      hs_sr <= '0;
      vs_sr <= '0;
      hcnt <= '0;
      hhigh <= '0;
      line_period <= '0;
      line_pol <= 1'b0;
      vcnt <= '0;
      vhigh <= '0;
    end else begin
      hs_sr <= {hs_sr[1:0], vm.hs_in};
      vs_sr <= {vs_sr[1:0], vm.vs_in};
      hcnt <= hs_rise ? 12'd1 : hcnt + {11'd0, hcnt != 12'hfff};
      hhigh <= hs_rise ? 12'd1 : hhigh + {11'd0, hs_sr[1] && hhigh != 12'hfff};
      if (hs_rise) begin
        line_period <= hcnt;
        line_pol <= hs_pol_m;
      end
      vcnt <= vs_rise ? '0 : vcnt_f;
      vhigh <= vs_rise ? '0 : vhigh_f;
    end
  function automatic logic match(samp_t a, samp_t b);
    logic [11:0] d;
    d = a.hp > b.hp ? a.hp - b.hp : b.hp - a.hp;
    return a.vl == b.vl && a.hs == b.hs && a.vs == b.vs && d <= 12'(TOL);
  endfunction
  always_comb begin
    state_n = state;
    p_n = p;
    c_n = c;
    valid_n = valid;
    if (timeout) begin
      state_n = NOSIG;
      valid_n = 1'b0;
    end else if (vs_rise)
      case (state)
        NOSIG: begin
          p_n = f;
          state_n = ACQUIRE;
        end
        ACQUIRE:
          if (match(f, p)) begin
            c_n = f;
            valid_n = 1'b1;
            state_n = LOCKED;
          end else p_n = f;
        default:
          if (!match(f, c)) begin
            valid_n = 1'b0;
            p_n = f;
            state_n = ACQUIRE;
          end
      endcase
    changed_n = c_n != c || valid_n != valid;
  end
  always_ff @(posedge clk_32 or posedge reset)
    if (reset) begin
      state <= NOSIG;
      p <= '0;
      c <= '0;
      valid <= 1'b0;
      changed <= 1'b0;
    end else begin
      state <= state_n;
      p <= p_n;
      c <= c_n;
      valid <= valid_n;
      changed <= changed_n;
    end
  assign vm.h_period = c.hp;
  assign vm.v_lines = c.vl;
  assign vm.hs_pol = c.hs;
  assign vm.vs_pol = c.vs;
  assign vm.valid = valid;
  assign vm.changed = changed;
  assign vm.is15k = valid && c.hp >= 12'd1792 && c.hp <= 12'd2304;
  assign vm.is31k = valid && c.hp >= 12'd864 && c.hp <= 12'd1152;
endmodule

// File: tb/tb_video_mode_detect.sv
// tb_video_mode_detect: directed mode vectors plus lock, jitter, timeout and reset sequences.
module tb_video_mode_detect;
  typedef struct {
    int len; int pw; int hs_hi; int lines; int vs_hi;
    int hp; int vl; int hpol; int vpol; int k15; int k31;
  } vec_t;
  logic clk_32 = 1'b0;
  logic reset = 1'b1;
  int cyc = 0, nchg = 0, last_rise = 0, tests = 0, fails = 0, base = 0;
  vec_t vt[4];
  video_mode_detect_if vm();
  video_mode_detect dut(.clk_32(clk_32), .reset(reset), .vm(vm));
  always #5 clk_32 = ~clk_32;
  always @(posedge clk_32) cyc <= cyc + 1;
  always @(negedge clk_32) if (vm.changed === 1'b1) nchg <= nchg + 1;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input int h, input int v);
    @(negedge clk_32);
    if (h != 0 && vm.hs_in == 1'b0) last_rise = cyc;
    vm.hs_in = (h != 0);
    vm.vs_in = (v != 0);
  endtask
  task automatic frame(input int len, input int pw, input int hs_hi, input int lines, input int vs_hi);
    for (int l = 0; l < lines; l++)
      for (int i = 0; i < len; i++)
        drive(i < pw ? hs_hi : 1 - hs_hi, l == 0 ? vs_hi : 1 - vs_hi);
  endtask
  task automatic do_reset();
    @(negedge clk_32);
    #2 reset = 1'b1;
    @(negedge clk_32);
    #2 reset = 1'b0;
  endtask
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end
  initial begin
    vt[0] = '{2040, 128, 0, 3, 0, 2040, 3, 0, 0, 1, 0};
    vt[1] = '{896, 64, 1, 3, 1, 896, 3, 1, 1, 0, 1};
    vt[2] = '{1152, 64, 1, 4, 1, 1152, 4, 1, 1, 0, 1};
    vt[3] = '{1153, 64, 0, 3, 1, 1153, 3, 0, 1, 0, 0};
    vm.hs_in = 1'b0;
    vm.vs_in = 1'b0;
    #7;
    chk("reset h_period", int'(vm.h_period), 0);
    chk("reset v_lines", int'(vm.v_lines), 0);
    chk("reset valid", int'(vm.valid), 0);
    chk("reset changed", int'(vm.changed), 0);
    foreach (vt[i]) begin
      vm.hs_in = (vt[i].hs_hi == 0);
      vm.vs_in = (vt[i].vs_hi == 0);
      do_reset();
      base = nchg;
      frame(vt[i].len, vt[i].pw, vt[i].hs_hi, vt[i].lines, vt[i].vs_hi);
      frame(vt[i].len, vt[i].pw, vt[i].hs_hi, vt[i].lines, vt[i].vs_hi);
      #2 chk($sformatf("v%0d valid after 2 frames", i), int'(vm.valid), 0);
      frame(vt[i].len, vt[i].pw, vt[i].hs_hi, vt[i].lines, vt[i].vs_hi);
      #2;
      chk($sformatf("v%0d valid", i), int'(vm.valid), 1);
      chk($sformatf("v%0d h_period", i), int'(vm.h_period), vt[i].hp);
      chk($sformatf("v%0d v_lines", i), int'(vm.v_lines), vt[i].vl);
      chk($sformatf("v%0d hs_pol", i), int'(vm.hs_pol), vt[i].hpol);
      chk($sformatf("v%0d vs_pol", i), int'(vm.vs_pol), vt[i].vpol);
      chk($sformatf("v%0d is15k", i), int'(vm.is15k), vt[i].k15);
      chk($sformatf("v%0d is31k", i), int'(vm.is31k), vt[i].k31);
      chk($sformatf("v%0d changed pulses", i), nchg - base, 1);
    end
    vm.hs_in = 1'b1;
    vm.vs_in = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) frame(200, 16, 0, 3, 0);
    #2;
    chk("seq lock valid", int'(vm.valid), 1);
    chk("seq lock h_period", int'(vm.h_period), 200);
    base = nchg;
    for (int k = 0; k < 4; k++) begin
      frame(k % 2 ? 201 : 199, 16, 0, 3, 0);
      #2;
      chk("jitter valid", int'(vm.valid), 1);
      chk("jitter h_period", int'(vm.h_period), 200);
    end
    chk("jitter changed pulses", nchg - base, 0);
    frame(210, 16, 0, 3, 0);
    #2 chk("step frame1 valid", int'(vm.valid), 1);
    base = nchg;
    frame(210, 16, 0, 3, 0);
    #2;
    chk("step frame2 valid", int'(vm.valid), 0);
    chk("step frame2 changed pulses", nchg - base, 1);
    frame(210, 16, 0, 3, 0);
    #2;
    chk("step relock valid", int'(vm.valid), 1);
    chk("step relock h_period", int'(vm.h_period), 210);
    chk("step changed pulses", nchg - base, 2);
    base = nchg;
    while (cyc < last_rise + 4097) drive(1, 1);
    #2 chk("timeout valid before", int'(vm.valid), 1);
    drive(1, 1);
    #2;
    chk("timeout valid", int'(vm.valid), 0);
    chk("timeout changed", int'(vm.changed), 1);
    chk("timeout changed pulses", nchg - base, 1);
    chk("timeout h_period hold", int'(vm.h_period), 210);
    chk("timeout v_lines hold", int'(vm.v_lines), 3);
    chk("timeout is15k", int'(vm.is15k), 0);
    frame(200, 16, 0, 3, 0);
    frame(200, 16, 0, 3, 0);
    #2 chk("return valid after 2 frames", int'(vm.valid), 0);
    frame(200, 16, 0, 3, 0);
    #2;
    chk("return valid", int'(vm.valid), 1);
    chk("return h_period", int'(vm.h_period), 200);
    fork
      frame(200, 16, 0, 3, 0);
      begin
        repeat (50) @(negedge clk_32);
        #2 reset = 1'b1;
        #1;
        chk("async reset h_period", int'(vm.h_period), 0);
        chk("async reset v_lines", int'(vm.v_lines), 0);
        chk("async reset valid", int'(vm.valid), 0);
        chk("async reset changed", int'(vm.changed), 0);
        @(negedge clk_32);
        #2 reset = 1'b0;
      end
    join
    frame(200, 16, 0, 3, 0);
    #2 chk("post reset valid 2nd vs", int'(vm.valid), 0);
    frame(200, 16, 0, 3, 0);
    #2;
    chk("post reset valid 3rd vs", int'(vm.valid), 1);
    chk("post reset h_period", int'(vm.h_period), 200);
    chk("post reset v_lines", int'(vm.v_lines), 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/video_mode_detect.md
# video_mode_detect

Measures the sync timing of the video stream leaving the ST/Viking video path (after sync adjustment, before OSD and output muxing) and reports line period, lines per frame, sync polarities and a 15 kHz/31 kHz classification. It feeds the OSD and the output stage with a stable, debounced mode descriptor, so polarity and csync decisions come from measured timing rather than register guesses. Fully synchronous to clk_32; sync inputs may originate in other clock domains and are resynchronised internally.

## Interface
- TOL, default 2: maximum |Δh_period| in clk_32 cycles between two frames still considered identical.
- clk_32  in  1  31.875 MHz system video clock.
- reset  in  1  asynchronous, active-high reset.
- hs_in  in  1  horizontal sync, either polarity, any clock domain.
- vs_in  in  1  vertical sync, either polarity, any clock domain.
- h_period  out  12  committed clk_32 cycles between hs rising edges.
- v_lines  out  11  committed hs rising edges per frame.
- hs_pol  out  1  1 = hsync active high.
- vs_pol  out  1  1 = vsync active high.
- is15k  out  1  valid and h_period in [1792,2304].
- is31k  out  1  valid and h_period in [864,1152].
- valid  out  1  committed descriptor is stable.
- changed  out  1  one-cycle pulse whenever any committed output changes.

## Operation
- Input stage: two-flop synchroniser per sync input, then a third flop for edge detect; rise = s & ~s_d.
- Line counter hcnt (12 bit): cleared to 1 on hs rise, otherwise increments, saturating at 4095. hhigh (12 bit) counts cycles with hs high since the last hs rise, also saturating.
- On hs rise: line_period ← hcnt; line_pol ← (2·hhigh < hcnt), i.e. high phase shorter than half the line means active high. Comparison done at 13 bits.
- Frame counter vcnt (11 bit): incremented on each hs rise, saturating at 2047; vhigh counts hs rises while vs is high.
- On vs rise: frame sample F = {line_period, vcnt, line_pol, vs_pol_meas = (2·vhigh < vcnt)}; vcnt and vhigh restart at 0. The previous sample P is retained.
- State machine, states NOSIG, ACQUIRE, LOCKED:
  - NOSIG (reset state): on first vs rise store P, go to ACQUIRE.
  - ACQUIRE: on vs rise, if F matches P, commit F to outputs, set valid, go to LOCKED; else P ← F, stay.
  - LOCKED: on vs rise, if F matches the committed values, no update; else clear valid, P ← F, go to ACQUIRE.
  - Any state: hcnt reaching 4095 or vcnt reaching 2047 → clear valid, go to NOSIG.
- Match: v_lines equal, both polarities equal, |Δline_period| ≤ TOL.
- On commit, h_period takes the new sample even when within TOL of the old one only on entry from ACQUIRE; in LOCKED, in-tolerance jitter never updates outputs.
- changed pulses on the cycle any of h_period, v_lines, hs_pol, vs_pol or valid changes value.
- is15k/is31k are combinational from committed h_period and valid; both 0 when not valid.

## Timing
- Reset: all outputs 0, state NOSIG, all counters 0; takes effect immediately, regardless of clock.
- Sync input to internal edge: 3 clk_32 cycles from the pin transition.
- Committed outputs and valid update on the clock edge following the internal vs rise; changed asserts in that same cycle, for exactly 1 cycle.
- Simultaneous hs rise and vs rise: the hs rise is counted into the closing frame first (vcnt includes it), then the frame sample is taken.
- Minimum lock time: the 3rd vs rise after reset or signal return (sample, match, commit).
- Timeout: valid drops 4095 cycles after the last hs rise (~128 µs) or 2047 lines without vs. h_period, v_lines and the polarities hold their last values.
- Reset asserted mid-frame: the next frame restarts from NOSIG, with no partial measurement retained.

## Test plan
- PAL ST, 2040-cycle lines, 4 µs low hsync, 313 lines, low vsync → after 3rd vs: h_period=2040, v_lines=313, hs_pol=0, vs_pol=0, is15k=1, valid=1, one changed pulse.
- Mono 71 Hz, 896-cycle lines, high hsync, 501 lines, high vsync → h_period=896, v_lines=501, hs_pol=1, vs_pol=1, is31k=1, is15k=0.
- Locked PAL with line period alternating 2039/2041 → valid stays 1, h_period stays 2040, no changed pulses; a step to 2050 → valid=0 with changed pulse, then relock at 2050 two frames later.
- hs_in stopped while locked → valid=0 exactly 4095 cycles after the last hs rise, changed pulse, is15k=0, h_period holds 2040.
- Asynchronous reset mid-frame while locked → all outputs 0 at once; lock is regained at the 3rd vs rise after release.
- hs and vs rising on the same clk_32 edge, 262-line NTSC → v_lines=262 (no off-by-one).
